// File: rtl/dram_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : dram_uart_tx
// Purpose  : Reads NUM_BYTES processed pixels from data memory starting at
//            BASE_ADDR and sends each one as an 8N1 UART frame, LSB first.
//            It raises end_transmit when the last frame has gone out.
//            The DRAM read port is shared through the external address mux
//            and belongs to this block only while tx_busy is high.
// Ports    : clock          system clock
//            rst_n          asynchronous active-low reset
//            begin_transmit level request from main_control
//            dm_data[7:0]   DRAM read data
//            dm_addr[19:0]  DRAM read address
//            dm_rd          one-cycle read strobe per byte
//            tx             UART serial line, idle high
//            tx_busy        high from leaving IDLE until entering DONE
//            end_transmit   completion flag, held until begin_transmit drops
// Options  : DRAM_UART_TX_CHECKSUM_EN - appends one extra frame carrying the
//            XOR of all transmitted data bytes.
// Legal    : CLKS_PER_BIT >= 2, NUM_BYTES >= 1, RD_LATENCY >= 1
// Revision : 1.0 - initial release
// ============================================================================
module dram_uart_tx #(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          NUM_BYTES    = 16384,
   parameter logic [19:0] BASE_ADDR    = 20'd0,
   parameter int          RD_LATENCY   = 2
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        begin_transmit,
   input  logic [7:0]  dm_data,
   output logic [19:0] dm_addr,
   output logic        dm_rd,
   output logic        tx,
   output logic        tx_busy,
   output logic        end_transmit
);

   // Index must hold NUM_BYTES itself so the increment can never overflow.
   localparam int IDX_W  = $clog2(NUM_BYTES + 1);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   // Wait counter covers RD_LATENCY+1 cycles for the checksum gap.
   localparam int WAIT_W = $clog2(RD_LATENCY + 2);

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BYTES - 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY - 1);
`ifdef DRAM_UART_TX_CHECKSUM_EN
   localparam logic [WAIT_W-1:0] WAIT_CS_LAST = WAIT_W'(RD_LATENCY);
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_START = 3'd3,
      S_DATA  = 3'd4,
      S_STOP  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    index;
   logic [2:0]          bit_cnt;
   logic [BAUD_W-1:0]   baud_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [7:0]          shreg;

   logic                baud_done;
   logic [IDX_W-1:0]    index_inc;
   logic [19:0]         next_addr;
   logic [WAIT_W-1:0]   wait_last;

`ifdef DRAM_UART_TX_CHECKSUM_EN
   logic [7:0]          csum;
   // Set once the last data frame is out; the next frame is the checksum.
   logic                csum_phase;
`endif

   assign baud_done = (baud_cnt == BAUD_LAST);
   assign index_inc = index + IDX_W'(1);
   // Address arithmetic is modulo 2^20, so a base near the top wraps.
   assign next_addr = BASE_ADDR + 20'(index_inc);

`ifdef DRAM_UART_TX_CHECKSUM_EN
   // The checksum gap has no FETCH cycle, so WAIT runs one cycle longer to
   // keep the idle gap at RD_LATENCY+1.
   assign wait_last = csum_phase ? WAIT_CS_LAST : WAIT_LAST;
`else
   assign wait_last = WAIT_LAST;
`endif

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         index        <= '0;
         bit_cnt      <= '0;
         baud_cnt     <= '0;
         wait_cnt     <= '0;
         shreg        <= '0;
         dm_addr      <= BASE_ADDR;
         dm_rd        <= 1'b0;
         tx           <= 1'b1;
         tx_busy      <= 1'b0;
         end_transmit <= 1'b0;
`ifdef DRAM_UART_TX_CHECKSUM_EN
         csum         <= '0;
         csum_phase   <= 1'b0;
`endif
      end else begin
         // The read strobe is a single-cycle pulse unless a branch sets it.
         dm_rd    <= 1'b0;
         // Free-running bit timer; every state change below clears it.
         baud_cnt <= baud_done ? '0 : baud_cnt + BAUD_W'(1);

         case (state)
            S_IDLE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               if (begin_transmit) begin
                  index    <= '0;
                  tx_busy  <= 1'b1;
                  dm_rd    <= 1'b1;
                  dm_addr  <= BASE_ADDR;
                  state    <= S_FETCH;
`ifdef DRAM_UART_TX_CHECKSUM_EN
                  csum       <= '0;
                  csum_phase <= 1'b0;
`endif
               end
            end

            S_FETCH: begin
               wait_cnt <= '0;
               baud_cnt <= '0;
               state    <= S_WAIT;
            end

            S_WAIT: begin
               baud_cnt <= '0;
               if (wait_cnt == wait_last) begin
`ifdef DRAM_UART_TX_CHECKSUM_EN
                  if (csum_phase) begin
                     shreg <= csum;
                  end else begin
                     shreg <= dm_data;
                     csum  <= csum ^ dm_data;
                  end
`else
                  shreg <= dm_data;
`endif
                  tx    <= 1'b0;
                  state <= S_START;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end

            S_START: begin
               if (baud_done) begin
                  tx       <= shreg[0];
                  bit_cnt  <= '0;
                  baud_cnt <= '0;
                  state    <= S_DATA;
               end
            end

            S_DATA: begin
               if (baud_done) begin
                  if (bit_cnt == 3'd7) begin
                     tx       <= 1'b1;
                     baud_cnt <= '0;
                     state    <= S_STOP;
                  end else begin
                     // shreg[0] is on the line now; shreg[1] goes out next.
                     tx      <= shreg[1];
                     shreg   <= {1'b0, shreg[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end

            S_STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (index == LAST_IDX) begin
`ifdef DRAM_UART_TX_CHECKSUM_EN
                     if (!csum_phase) begin
                        csum_phase <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= S_WAIT;
                     end else begin
                        tx_busy      <= 1'b0;
                        end_transmit <= 1'b1;
                        state        <= S_DONE;
                     end
`else
                     tx_busy      <= 1'b0;
                     end_transmit <= 1'b1;
                     state        <= S_DONE;
`endif
                  end else begin
                     index   <= index_inc;
                     dm_addr <= next_addr;
                     dm_rd   <= 1'b1;
                     state   <= S_FETCH;
                  end
               end
            end

            S_DONE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               // Only a released request re-arms the block, so a held
               // begin_transmit cannot trigger a second transmission.
               if (!begin_transmit) begin
                  end_transmit <= 1'b0;
                  state        <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dram_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_uart_tx
// Purpose  : Self-checking bench for dram_uart_tx. Two instances: A sends
//            three bytes from address 0, B sends one byte from 20'hFFFFF.
//            Each frame is checked cycle-exactly: read strobe and address,
//            idle gap, and the full 10-bit waveform at CLKS_PER_BIT=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_uart_tx;

   localparam int CPB   = 4;
   localparam int NB    = 3;
   localparam int RL    = 2;
   localparam int FRAME = 10 * CPB;
`ifdef DRAM_UART_TX_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   typedef struct {
      logic        rd;     // frame is preceded by a DRAM read
      logic [19:0] addr;   // expected read address
      logic [7:0]  data;   // expected byte on the line
   } vec_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        rst_n = 1'b0;
   logic        bt_a = 1'b0, bt_b = 1'b0;
   logic [7:0]  dd_a = 8'h00, dd_b = 8'h00;
   logic [7:0]  pa0 = 8'h00, pb0 = 8'h00;
   logic [19:0] addr_a, addr_b;
   logic        rd_a, rd_b, tx_a, tx_b, busy_a, busy_b, end_a, end_b;

   dram_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .BASE_ADDR(20'd0),
                  .RD_LATENCY(RL)) dut_a (
      .clock(clock), .rst_n(rst_n), .begin_transmit(bt_a), .dm_data(dd_a),
      .dm_addr(addr_a), .dm_rd(rd_a), .tx(tx_a), .tx_busy(busy_a),
      .end_transmit(end_a));

   dram_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(1), .BASE_ADDR(20'hFFFFF),
                  .RD_LATENCY(RL)) dut_b (
      .clock(clock), .rst_n(rst_n), .begin_transmit(bt_b), .dm_data(dd_b),
      .dm_addr(addr_b), .dm_rd(rd_b), .tx(tx_b), .tx_busy(busy_b),
      .end_transmit(end_b));

   function automatic logic [7:0] mem_a(input logic [19:0] a);
      case (a)
         20'd0:   return 8'hA5;
         20'd1:   return 8'h3C;
         20'd2:   return 8'hFF;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] mem_b(input logic [19:0] a);
      return (a == 20'hFFFFF) ? 8'h5A : 8'hC3;
   endfunction

   // Two-stage memory: data is valid only in the single cycle exactly
   // RL cycles after the read strobe, zero otherwise.
   int rd_b_cnt = 0;
   always @(posedge clock) begin
      pa0 <= rd_a ? mem_a(addr_a) : 8'h00;
      dd_a <= pa0;
      pb0 <= rd_b ? mem_b(addr_b) : 8'h00;
      dd_b <= pb0;
      if (rd_b) rd_b_cnt <= rd_b_cnt + 1;
   end

   // Monitor mux so one frame checker serves both instances.
   logic        sel = 1'b0;
   logic        m_tx, m_rd, m_busy, m_end;
   logic [19:0] m_addr;
   assign m_tx   = sel ? tx_b   : tx_a;
   assign m_rd   = sel ? rd_b   : rd_a;
   assign m_busy = sel ? busy_b : busy_a;
   assign m_end  = sel ? end_b  : end_a;
   assign m_addr = sel ? addr_b : addr_a;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Call right after the sample of the cycle preceding the FETCH cycle
   // (or the checksum gap). Returns on the sample of the last stop cycle.
   task automatic run_frame(input vec_t v, input int idx);
      logic [RL:0]      gap;
      logic [RL-1:0]    rdw;
      logic [FRAME-1:0] cap;
      logic [FRAME-1:0] exp;
      @(negedge clock);
      chk($sformatf("f%0d_rd", idx), m_rd, v.rd);
      if (v.rd) chk($sformatf("f%0d_addr", idx), m_addr, v.addr);
      chk($sformatf("f%0d_busy", idx), m_busy, 1);
      gap[0] = m_tx;
      for (int i = 1; i <= RL; i++) begin
         @(negedge clock);
         gap[i]   = m_tx;
         rdw[i-1] = m_rd;
      end
      chk($sformatf("f%0d_gap", idx), gap, {(RL+1){1'b1}});
      chk($sformatf("f%0d_wait_rd", idx), rdw, 0);
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clock);
         cap[i] = m_tx;
         if (i < CPB)          exp[i] = 1'b0;
         else if (i >= 9*CPB)  exp[i] = 1'b1;
         else                  exp[i] = v.data[(i - CPB) / CPB];
      end
      chk($sformatf("f%0d_frame", idx), cap, exp);
   endtask

   task automatic check_done(input string tag);
      @(negedge clock);
      chk({tag, "_end"},  m_end,  1);
      chk({tag, "_busy"}, m_busy, 0);
      chk({tag, "_tx"},   m_tx,   1);
   endtask

   vec_t tbl_a [NB+CS];
   vec_t tbl_b [1+CS];

   initial begin
      int bad;
      tbl_a[0] = '{1'b1, 20'd0, 8'hA5};
      tbl_a[1] = '{1'b1, 20'd1, 8'h3C};
      tbl_a[2] = '{1'b1, 20'd2, 8'hFF};
      tbl_b[0] = '{1'b1, 20'hFFFFF, 8'h5A};
`ifdef DRAM_UART_TX_CHECKSUM_EN
      tbl_a[3] = '{1'b0, 20'd0, 8'h66};
      tbl_b[1] = '{1'b0, 20'd0, 8'h5A};
`endif

      // Reset with begin_transmit asserted.
      rst_n = 1'b0; bt_a = 1'b1; bt_b = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_tx",    tx_a,   1);
      chk("rst_busy",  busy_a, 0);
      chk("rst_end",   end_a,  0);
      chk("rst_rd",    rd_a,   0);
      chk("rst_addr",  addr_a, 20'd0);
      chk("rst_addrB", addr_b, 20'hFFFFF);

      bt_a = 1'b0; bt_b = 1'b0;
      rst_n = 1'b1;
      @(negedge clock);
      chk("idle_tx",   tx_a,   1);
      chk("idle_busy", busy_a, 0);

      // First transmission.
      bt_a = 1'b1;
      for (int i = 0; i < NB+CS; i++) run_frame(tbl_a[i], i);
      check_done("done1");

      // Held request after DONE must stay quiet.
      bad = 0;
      repeat (200) begin
         @(negedge clock);
         if (m_rd || !m_tx || !m_end || m_busy) bad++;
      end
      chk("hold_quiet", bad, 0);

      bt_a = 1'b0;
      @(negedge clock);
      chk("drop_end", end_a, 0);

      // Re-request repeats the whole sequence from address 0.
      bt_a = 1'b1;
      for (int i = 0; i < NB+CS; i++) run_frame(tbl_a[i], 10 + i);
      check_done("done2");

      // Restart, then reset during the 5th data bit of byte 1.
      bt_a = 1'b0;
      @(negedge clock);
      bt_a = 1'b1;
      run_frame(tbl_a[0], 20);
      @(negedge clock);
      chk("b1_rd",   rd_a,   1);
      chk("b1_addr", addr_a, 20'd1);
      repeat (RL + CPB + 4*CPB + 2) @(negedge clock);
      chk("b1_bit4", tx_a,   1);
      chk("b1_busy", busy_a, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_tx",   tx_a,   1);
      chk("mid_rst_busy", busy_a, 0);
      chk("mid_rst_rd",   rd_a,   0);
      chk("mid_rst_addr", addr_a, 20'd0);
      @(negedge clock);
      rst_n = 1'b1;
      for (int i = 0; i < NB+CS; i++) run_frame(tbl_a[i], 30 + i);
      check_done("done3");

      // Single byte at the top of the address space.
      bt_a = 1'b0;
      sel  = 1'b1;
      bt_b = 1'b1;
      for (int i = 0; i < 1+CS; i++) run_frame(tbl_b[i], 40 + i);
      check_done("doneB");
      chk("B_rd_count", rd_b_cnt, 1);
      bt_b = 1'b0;
      repeat (20) @(negedge clock);
      chk("B_no_wrap", rd_b_cnt, 1);
      chk("B_idle_end", end_b, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares", n_err);
      $fatal(1);
   end

endmodule
`default_nettype wire
